// File: rtl/pc_exception_unit.sv
// PC sequencer for the MIPS datapath with precise exceptions, EPC/CAUSE capture,
// a RUN/HANDLER/HALT mode FSM and a saturating taken-exception counter.
module pc_exception_unit #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] EXC_VEC   = 'h80,
    parameter int              EXC_N     = 4,
    parameter int              CNT_W     = 8,
    localparam int             CW        = (EXC_N > 1) ? $clog2(EXC_N) : 1
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             SYS_load,
    input  logic [PC_W-1:0]  SYS_pc_val,
    input  logic             stall,
    input  logic [31:0]      instruction,
    input  logic             branch,
    input  logic             zero,
    input  logic             jump,
    input  logic [EXC_N-1:0] exc_req,
    input  logic             eret,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  epc,
    output logic [CW-1:0]    cause,
    output logic             in_handler,
    output logic             halted,
    output logic             flush,
    output logic [CNT_W-1:0] exc_count
);

    typedef enum logic [1:0] {RUN, HANDLER, HALT} state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_d, epc_d;
    logic [CW-1:0]    cause_d, exc_idx;
    logic [CNT_W-1:0] cnt_d, cnt_inc;
    logic [PC_W-1:0]  pc4, br_off, br_tgt, jmp_tgt;
    logic [5:0]       opcode;
    logic             br_taken, exc_any;

    assign opcode   = instruction[31:26];
    assign exc_any  = |exc_req;
    assign flush    = exc_any;
    assign pc4      = pc + PC_W'(4);
    assign br_off   = {{(PC_W-18){instruction[15]}}, instruction[15:0], 2'b00};
    assign br_tgt   = pc4 + br_off;
    assign br_taken = branch && (((opcode == 6'h04) && zero) || ((opcode == 6'h05) && !zero));
    assign cnt_inc  = (exc_count == '1) ? exc_count : exc_count + CNT_W'(1);

    assign in_handler = (state_q == HANDLER);
    assign halted     = (state_q == HALT);

    // Jump keeps the pc4 bits above 27; with PC_W=28 the whole PC is the jump field.
    always_comb begin
        jmp_tgt       = pc4;
        jmp_tgt[27:0] = {instruction[25:0], 2'b00};
    end

    // Lowest set request index wins, so scan from the top down.
    always_comb begin
        exc_idx = '0;
        for (int i = EXC_N - 1; i >= 0; i--) begin
            if (exc_req[i]) exc_idx = CW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        epc_d   = epc;
        cause_d = cause;
        cnt_d   = exc_count;
        if (SYS_load) begin
            pc_d    = {SYS_pc_val[PC_W-1:2], 2'b00};
            state_d = RUN;
        end else if (state_q == HALT) begin
            state_d = HALT;
        end else if (exc_any && (state_q == RUN)) begin
            epc_d   = pc;
            cause_d = exc_idx;
            pc_d    = EXC_VEC;
            state_d = HANDLER;
            cnt_d   = cnt_inc;
        end else if (exc_any) begin
            // A fault while already handling one is unrecoverable.
            state_d = HALT;
            cnt_d   = cnt_inc;
        end else if (eret && (state_q == HANDLER)) begin
            pc_d    = epc + PC_W'(4);
            state_d = RUN;
        end else if (stall) begin
            pc_d = pc;
        end else if (jump) begin
            pc_d = jmp_tgt;
        end else if (br_taken) begin
            pc_d = br_tgt;
        end else begin
            pc_d = pc4;
        end
    end

    always_ff @(negedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q   <= RUN;
            pc        <= RESET_VEC;
            epc       <= '0;
            cause     <= '0;
            exc_count <= '0;
        end else begin
            state_q   <= state_d;
            pc        <= pc_d;
            epc       <= epc_d;
            cause     <= cause_d;
            exc_count <= cnt_d;
        end
    end

endmodule
